piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
Parallel-in serial-out framer that sits directly upstream of the team's serial-in shift-register stage. It drives that stage's `d` input one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Double-buffers through a one-word holding register, so the producer can queue the next word while the current one shifts out.
- Marks each frame with start/end strobes and an optional inter-frame gap.

Parameters:
WIDTH, 8, data word width in bits (minimum 2)
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first
GAP_CYCLES, 0, idle cycles inserted after every frame (0 = back-to-back)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word from producer
in_valid  input  1  producer has a word on in_data
in_ready  output  1  holding register empty; word accepted when in_valid & in_ready at rising edge
d_out  output  1  serial bit to downstream shift-register stage (its `d`)
d_valid  output  1  d_out carries a frame bit this cycle
sof  output  1  first bit of frame
eof  output  1  last bit of frame
busy  output  1  state != IDLE or holding register occupied

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - state=IDLE, hold_valid=0, shift reg=0, bit counter=0, gap counter=0.
  - Outputs: d_out=0, d_valid=0, sof=0, eof=0, busy=0, in_ready=1.
- All outputs are registered except in_ready and busy.
  - in_ready = ~hold_valid.
  - busy = (state!=IDLE) | hold_valid.
- Holding register: loads in_data on accept, sets hold_valid. Cleared when its word is transferred to the shift register; a transfer edge and an accept edge cannot coincide because in_ready=0 while hold_valid=1.
- States: IDLE, SHIFT, GAP.
  - IDLE: d_valid=0, d_out=0. If hold_valid, next edge loads the shift register from hold, clears hold_valid, bit counter=0, goes to SHIFT.
  - SHIFT: one bit per cycle, d_valid=1.
    - Bit order follows MSB_FIRST.
    - sof=1 when counter=0; eof=1 when counter=FRAME_LEN-1.
    - FRAME_LEN = WIDTH, or WIDTH+1 with parity (see Optional Feature).
    - After the last bit:
      - If GAP_CYCLES>0: go to GAP, gap counter=0.
      - Else if hold_valid: reload and stay in SHIFT, giving a seamless next frame (sof directly after eof).
      - Else: go to IDLE.
  - GAP: d_valid=0, d_out=0 for exactly GAP_CYCLES cycles. Then reload if hold_valid (to SHIFT), else go to IDLE.
- Latency: word accepted at edge N → its first bit valid in the cycle after edge N+1 (2 edges). A frame occupies FRAME_LEN consecutive d_valid cycles.
- Counter widths:
  - Bit counter is $clog2(WIDTH+1) bits.
  - Gap counter is $clog2(GAP_CYCLES+1) bits, with a minimum of 1.
  - No wrap beyond FRAME_LEN-1.
- Throughput: with GAP_CYCLES=0 and a producer that keeps in_valid high, d_valid stays continuously 1.
- Producer holds off: when in_ready=0, in_data/in_valid are ignored and the word must be held by the producer.
- Reset mid-frame: frame truncated immediately, no eof issued, queued word discarded.
- WIDTH=2 edge case: sof and eof fall on adjacent cycles. sof and eof are never asserted together.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: each frame carries one extra bit after the data bits: even parity = XOR of all WIDTH data bits. FRAME_LEN=WIDTH+1, eof asserts on the parity bit.
- Not defined: FRAME_LEN=WIDTH, no parity logic, eof on the last data bit.

Test Plan:
- WIDTH=8, MSB_FIRST=1, GAP=0:
  - Single 0xA5 → d_out 1,0,1,0,0,1,0,1 on 8 consecutive d_valid cycles starting 2 edges after accept; sof on bit 1, eof on bit 8; then IDLE with busy=0.
  - Back-to-back 0xA5 then 0x3C, in_valid held → 16 continuous d_valid cycles, 0x3C bits 0,0,1,1,1,1,0,0; sof on cycle 9 immediately after eof on cycle 8.
- Backpressure: present 3 words while shifting → in_ready=0 whenever hold occupied; all 3 words emitted in order, none lost or duplicated.
- GAP_CYCLES=2, MSB_FIRST=0, words 0x01,0x80 → first frame 1,0,0,0,0,0,0,0; exactly 2 cycles d_valid=0; second frame 0,0,0,0,0,0,0,1.
- Reset: drive reset=0 mid-way through bit 4 of 0xFF, hold word queued → d_valid, sof, eof, busy drop to 0 immediately (no clock edge needed); in_ready=1; after release no bits emitted until a new accept.
- PISO_PARITY_EN defined, WIDTH=8, MSB_FIRST=1:
  - 0xA5 → 9 bits, ninth = 0, eof on ninth.
  - 0x07 → ninth bit = 1.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out framer with a one-word holding buffer, sof/eof strobes and optional gap.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit after the data bits of each frame.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             d_out,
  output logic             d_valid,
  output logic             sof,
  output logic             eof,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s, shifted_s, hold_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [GAP_W-1:0] gap_r, gap_s;
  logic             hold_valid_r, load_s, accept_s;
  logic             d_out_r, d_valid_r, sof_r, eof_r;
  logic             d_out_s, d_valid_s, sof_s, eof_s, data_bit_s, bit_s;
`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] PARITY_POS = CNT_W'(WIDTH);
  logic parity_r, parity_s;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction
`endif

  assign accept_s  = in_valid & ~hold_valid_r;
  assign in_ready  = ~hold_valid_r;
  assign busy      = (state_r != IDLE) | hold_valid_r;
  assign d_out     = d_out_r;
  assign d_valid   = d_valid_r;
  assign sof       = sof_r;
  assign eof       = eof_r;
  assign shifted_s = (MSB_FIRST != 0) ? {shreg_r[WIDTH-2:0], 1'b0} : {1'b0, shreg_r[WIDTH-1:1]};

  // Decide whether the holding register moves into the shift register on this edge
  always_comb begin
    load_s = 1'b0;
    case (state_r)
      IDLE:    load_s = hold_valid_r;
      SHIFT:   load_s = hold_valid_r && (cnt_r == BIT_LAST) && (GAP_CYCLES == 0);
      GAP:     load_s = hold_valid_r && (gap_r == GAP_LAST);
      default: load_s = 1'b0;
    endcase
  end

  // Next-state, shift and counter logic
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    gap_s   = gap_r;
    if (load_s) begin
      state_s = SHIFT;
      shreg_s = hold_r;
      cnt_s   = '0;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        SHIFT: begin
          if (cnt_r != BIT_LAST) begin
            cnt_s   = cnt_r + CNT_ONE;
            shreg_s = shifted_s;
          end else if (GAP_CYCLES > 0) begin
            state_s = GAP;
            gap_s   = '0;
          end else begin
            state_s = IDLE;
          end
        end
        GAP: begin
          if (gap_r != GAP_LAST) begin
            gap_s = gap_r + GAP_ONE;
          end else begin
            state_s = IDLE;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, taken from the next-state view so they can be registered
  always_comb begin
    d_valid_s  = (state_s == SHIFT);
    sof_s      = d_valid_s && (cnt_s == '0);
    eof_s      = d_valid_s && (cnt_s == BIT_LAST);
    data_bit_s = (MSB_FIRST != 0) ? shreg_s[WIDTH-1] : shreg_s[0];
`ifdef PISO_PARITY_EN
    parity_s = load_s ? even_parity(hold_r) : parity_r;
    if (cnt_s == PARITY_POS) begin
      bit_s = parity_s;
    end else begin
      bit_s = data_bit_s;
    end
`else
    bit_s = data_bit_s;
`endif
    d_out_s = d_valid_s && bit_s;
  end

  // Frame state, counters and registered serial outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      cnt_r     <= '0;
      gap_r     <= '0;
      d_out_r   <= 1'b0;
      d_valid_r <= 1'b0;
      sof_r     <= 1'b0;
      eof_r     <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      cnt_r     <= cnt_s;
      gap_r     <= gap_s;
      d_out_r   <= d_out_s;
      d_valid_r <= d_valid_s;
      sof_r     <= sof_s;
      eof_r     <= eof_s;
`ifdef PISO_PARITY_EN
      parity_r  <= parity_s;
`endif
    end
  end

  // Holding register: a transfer and an accept never share an edge since in_ready is low while full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_r <= 1'b0;
      hold_r       <= '0;
    end else if (load_s) begin
      hold_valid_r <= 1'b0;
    end else if (accept_s) begin
      hold_valid_r <= 1'b1;
      hold_r       <= in_data;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first no-gap instance and LSB-first two-cycle-gap instance.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] in_data0 = 8'h00, in_data1 = 8'h00;
  logic in_valid0 = 1'b0, in_valid1 = 1'b0;
  logic in_ready0, d_out0, d_valid0, sof0, eof0, busy0;
  logic in_ready1, d_out1, d_valid1, sof1, eof1, busy1;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .d_out(d_out0), .d_valid(d_valid0), .sof(sof0), .eof(eof0), .busy(busy0));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .d_out(d_out1), .d_valid(d_valid1), .sof(sof1), .eof(eof1), .busy(busy1));

  // Reference: k-th transmitted bit of a frame carrying word w
  function automatic logic frame_bit(input logic [7:0] w, input bit msb, input int k);
    if (k >= W) return ^w;
    return msb ? w[W-1-k] : w[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    n_tests++;
    if ({d_out0, d_valid0, sof0, eof0, busy0, in_ready0} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_dut0: got %b want 000001", {d_out0, d_valid0, sof0, eof0, busy0, in_ready0});
    end
    n_tests++;
    if ({d_out1, d_valid1, sof1, eof1, busy1, in_ready1} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_dut1: got %b want 000001", {d_out1, d_valid1, sof1, eof1, busy1, in_ready1});
    end
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic test_single(input logic [7:0] w);
    logic [3:0] got, exp;
    in_data0 = w;
    in_valid0 = 1'b1;
    n_tests++;
    if (in_ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready(%h): got %b want 1", w, in_ready0);
    end
    step();
    in_valid0 = 1'b0;
    n_tests++;
    if ({d_valid0, busy0} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_latency(%h): d_valid,busy got %b want 01", w, {d_valid0, busy0});
    end
    for (int k = 0; k < FL; k++) begin
      step();
      got = {d_valid0, d_out0, sof0, eof0};
      exp = {1'b1, frame_bit(w, 1'b1, k), (k == 0), (k == FL - 1)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL single_bit(%h,%0d): valid/out/sof/eof got %b want %b", w, k, got, exp);
      end
    end
    step();
    n_tests++;
    if ({d_valid0, eof0, busy0} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_idle(%h): valid/eof/busy got %b want 000", w, {d_valid0, eof0, busy0});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    logic [3:0] got, exp;
    logic rdy, v;
    int f, b;
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    in_data0 = words[0];
    in_valid0 = 1'b1;
    step();
    in_data0 = words[1];
    for (int k = 0; k < 2 * FL; k++) begin
      rdy = in_ready0;
      v = in_valid0;
      step();
      if (v && rdy) in_valid0 = 1'b0;
      f = k / FL;
      b = k % FL;
      got = {d_valid0, d_out0, sof0, eof0};
      exp = {1'b1, frame_bit(words[f], 1'b1, b), (b == 0), (b == FL - 1)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b2b_bit(%0d): valid/out/sof/eof got %b want %b", k, got, exp);
      end
    end
    n_tests++;
    if (in_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: second word still pending, got %b want 0", in_valid0);
    end
    in_valid0 = 1'b0;
    step();
    n_tests++;
    if ({d_valid0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_idle: valid,busy got %b want 00", {d_valid0, busy0});
    end
  endtask

  task automatic test_gap();
    logic [7:0] words [2];
    logic [3:0] got, exp;
    logic rdy, v;
    int b;
    words[0] = 8'h01;
    words[1] = 8'h80;
    in_data1 = words[0];
    in_valid1 = 1'b1;
    step();
    in_data1 = words[1];
    for (int k = 0; k < 2 * FL + 2; k++) begin
      rdy = in_ready1;
      v = in_valid1;
      step();
      if (v && rdy) in_valid1 = 1'b0;
      if (k < FL) begin
        exp = {1'b1, frame_bit(words[0], 1'b0, k), (k == 0), (k == FL - 1)};
      end else if (k < FL + 2) begin
        exp = 4'b0000;
      end else begin
        b = k - FL - 2;
        exp = {1'b1, frame_bit(words[1], 1'b0, b), (b == 0), (b == FL - 1)};
      end
      got = {d_valid1, d_out1, sof1, eof1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL gap_cycle(%0d): valid/out/sof/eof got %b want %b", k, got, exp);
      end
    end
    in_valid1 = 1'b0;
    step();
    step();
    step();
    n_tests++;
    if ({d_valid1, busy1} !== 2'b00) begin
      n_fail++;
      $display("FAIL gap_idle: valid,busy got %b want 00", {d_valid1, busy1});
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic [7:0] words [N];
    logic [7:0] exp_q [$];
    logic rdy, v;
    int idx, frames, bitpos;
    idx = 0;
    frames = 0;
    bitpos = -1;
    for (int i = 0; i < N; i++) words[i] = 8'($urandom);
    for (int c = 0; c < 600 && frames < N; c++) begin
      if (!in_valid0 && idx < N && $urandom_range(0, 3) != 0) begin
        in_data0 = words[idx];
        in_valid0 = 1'b1;
      end
      rdy = in_ready0;
      v = in_valid0;
      step();
      if (v && rdy) begin
        exp_q.push_back(in_data0);
        idx++;
        in_valid0 = 1'b0;
        n_tests++;
        if (in_ready0 !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready_after_accept(%0d): got %b want 0", idx, in_ready0);
        end
      end
      if (d_valid0) begin
        n_tests++;
        if (sof0 && eof0) begin
          n_fail++;
          $display("FAIL bp_sof_eof_together: got 1 want 0");
        end
        if (sof0) begin
          n_tests++;
          if (bitpos != -1) begin
            n_fail++;
            $display("FAIL bp_sof_midframe: bit position got %0d want -1", bitpos);
          end
          bitpos = 0;
        end
        if (bitpos < 0 || exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_stray_bit: bit position %0d, queued words %0d", bitpos, exp_q.size());
        end else begin
          n_tests++;
          if (d_out0 !== frame_bit(exp_q[0], 1'b1, bitpos)) begin
            n_fail++;
            $display("FAIL bp_bit(frame %0d,bit %0d): got %b want %b", frames, bitpos, d_out0,
                     frame_bit(exp_q[0], 1'b1, bitpos));
          end
          if (eof0) begin
            n_tests++;
            if (bitpos != FL - 1) begin
              n_fail++;
              $display("FAIL bp_eof_pos: got %0d want %0d", bitpos, FL - 1);
            end
            void'(exp_q.pop_front());
            frames++;
            bitpos = -1;
          end else begin
            bitpos++;
          end
        end
      end
    end
    in_valid0 = 1'b0;
    step();
    n_tests++;
    if (frames != N || idx != N || exp_q.size() != 0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: frames %0d accepted %0d left %0d busy %b want %0d %0d 0 0",
               frames, idx, exp_q.size(), busy0, N, N);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, v;
    int waited;
    in_data0 = 8'hFF;
    in_valid0 = 1'b1;
    step();
    in_data0 = 8'h5A;
    waited = 0;
    while (!(d_valid0 && sof0) && waited < 10) begin
      rdy = in_ready0;
      v = in_valid0;
      step();
      if (v && rdy) in_valid0 = 1'b0;
      waited++;
    end
    n_tests++;
    if (waited >= 10) begin
      n_fail++;
      $display("FAIL rst_mid_sof_timeout: waited %0d cycles want < 10", waited);
    end
    for (int k = 0; k < 3; k++) begin
      rdy = in_ready0;
      v = in_valid0;
      step();
      if (v && rdy) in_valid0 = 1'b0;
    end
    in_valid0 = 1'b0;
    n_tests++;
    if ({d_valid0, d_out0, busy0, in_ready0} !== 4'b1110) begin
      n_fail++;
      $display("FAIL rst_mid_pre: valid/out/busy/ready got %b want 1110", {d_valid0, d_out0, busy0, in_ready0});
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({d_valid0, d_out0, sof0, eof0, busy0, in_ready0} !== 6'b000001) begin
      n_fail++;
      $display("FAIL rst_mid_async: valid/out/sof/eof/busy/ready got %b want 000001",
               {d_valid0, d_out0, sof0, eof0, busy0, in_ready0});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      n_tests++;
      if ({d_valid0, eof0, busy0} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_mid_after(%0d): valid/eof/busy got %b want 000", k, {d_valid0, eof0, busy0});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'h07);
    test_single(8'($urandom));
    test_back_to_back();
    test_gap();
    test_backpressure();
    test_reset_mid();
    test_single(8'h3C);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
